ibis_vga_timing: RTL and testbench

Raster timing generator that sits directly upstream of the VGA pattern/colour stage. It divides aclk into a pixel strobe and walks horizontal and vertical counters through active, front-porch, sync and back-porch segments. It drives ord_x/ord_y and the enable qualifier consumed by the pattern stage, plus hsync/vsync/active for the DAC/encoder. Default timing is 640x480@60 with aclk = 5x pixel clock.

---
 rtl/ibis_vga_pkg.sv | 27 ++
 rtl/ibis_vga_axis.sv | 82 ++++++++
 rtl/ibis_vga_timing.sv | 91 +++++++++
 tb/tb_ibis_vga_timing.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/ibis_vga_pkg.sv
// Shared raster segment encoding, default 640x480@60 timing and a total-length helper.
package ibis_vga_pkg;

  typedef enum logic [1:0] {
    SEG_ACTIVE = 2'd0,
    SEG_FRONT  = 2'd1,
    SEG_SYNC   = 2'd2,
    SEG_BACK   = 2'd3
  } seg_state_t;

  localparam int DEF_WIDTH    = 10;
  localparam int DEF_PIX_DIV  = 5;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FRONT  = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BACK   = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FRONT  = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BACK   = 33;

  function automatic int calc_total(input int len_active, input int len_front,
                                    input int len_sync, input int len_back);
    return len_active + len_front + len_sync + len_back;
  endfunction

endpackage

// File: rtl/ibis_vga_axis.sv
// One raster axis: segment FSM (ACTIVE/FRONT/SYNC/BACK) plus position counter, advanced on i_tick.
module ibis_vga_axis
  import ibis_vga_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int L_ACTIVE = DEF_H_ACTIVE,
  parameter int L_FRONT  = DEF_H_FRONT,
  parameter int L_SYNC   = DEF_H_SYNC,
  parameter int L_BACK   = DEF_H_BACK
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_tick,
  output logic [WIDTH-1:0] o_pos,
  output seg_state_t       o_state,
  output logic             o_last
);

  localparam int TOTAL = calc_total(L_ACTIVE, L_FRONT, L_SYNC, L_BACK);
  localparam logic [WIDTH-1:0] POS_LAST = WIDTH'(TOTAL - 1);

  seg_state_t       r_state;
  seg_state_t       w_state_nxt;
  logic [WIDTH-1:0] r_seg_cnt;
  logic [WIDTH-1:0] w_seg_cnt_nxt;
  logic [WIDTH-1:0] r_pos;
  logic [WIDTH-1:0] w_pos_nxt;
  logic [WIDTH-1:0] w_seg_len_m1;
  logic             w_seg_done;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state   <= SEG_ACTIVE;
      r_seg_cnt <= '0;
      r_pos     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_seg_cnt <= w_seg_cnt_nxt;
      r_pos     <= w_pos_nxt;
    end
  end

  always_comb begin
    w_seg_len_m1 = WIDTH'(L_ACTIVE - 1);
    case (r_state)
      SEG_ACTIVE: w_seg_len_m1 = WIDTH'(L_ACTIVE - 1);
      SEG_FRONT:  w_seg_len_m1 = WIDTH'(L_FRONT - 1);
      SEG_SYNC:   w_seg_len_m1 = WIDTH'(L_SYNC - 1);
      SEG_BACK:   w_seg_len_m1 = WIDTH'(L_BACK - 1);
      default:    w_seg_len_m1 = WIDTH'(L_ACTIVE - 1);
    endcase
  end

  assign w_seg_done = (r_seg_cnt == w_seg_len_m1);

  always_comb begin
    w_state_nxt   = r_state;
    w_seg_cnt_nxt = r_seg_cnt;
    w_pos_nxt     = r_pos;
    if (i_tick) begin
      w_pos_nxt = (r_pos == POS_LAST) ? '0 : r_pos + 1'b1;
      if (w_seg_done) begin
        w_seg_cnt_nxt = '0;
        case (r_state)
          SEG_ACTIVE: w_state_nxt = SEG_FRONT;
          SEG_FRONT:  w_state_nxt = SEG_SYNC;
          SEG_SYNC:   w_state_nxt = SEG_BACK;
          SEG_BACK:   w_state_nxt = SEG_ACTIVE;
          default:    w_state_nxt = SEG_ACTIVE;
        endcase
      end else begin
        w_seg_cnt_nxt = r_seg_cnt + 1'b1;
      end
    end
  end

  // Last position of the axis is the final count of the BACK segment.
  assign o_last  = (r_state == SEG_BACK) && w_seg_done;
  assign o_pos   = r_pos;
  assign o_state = r_state;

endmodule

// File: rtl/ibis_vga_timing.sv
// VGA raster timing generator: pixel-strobe divider, H/V segment axes, sync/active decode.
module ibis_vga_timing
  import ibis_vga_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int PIX_DIV  = DEF_PIX_DIV,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FRONT  = DEF_H_FRONT,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BACK   = DEF_H_BACK,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FRONT  = DEF_V_FRONT,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BACK   = DEF_V_BACK,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             enable,
  output logic             pix_stb,
  output logic [WIDTH-1:0] ord_x,
  output logic [WIDTH-1:0] ord_y,
  output logic             hsync,
  output logic             vsync,
  output logic             active,
  output logic             frame_start
);

  localparam int DIV_W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);
  localparam int V_TOTAL = calc_total(V_ACTIVE, V_FRONT, V_SYNC, V_BACK);
  localparam logic [WIDTH-1:0] V_LAST = WIDTH'(V_TOTAL - 1);

  logic [DIV_W-1:0] r_div_cnt;
  logic             w_pix_stb;
  logic             w_h_last;
  logic             w_v_last;
  seg_state_t       w_h_state;
  seg_state_t       w_v_state;

  // With PIX_DIV=1 the counter stays at 0 and the strobe reduces to enable.
  assign w_pix_stb = enable && (r_div_cnt == DIV_LAST);

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_div_cnt <= '0;
    end else if (enable) begin
      r_div_cnt <= w_pix_stb ? '0 : r_div_cnt + 1'b1;
    end
  end

  ibis_vga_axis #(
    .WIDTH   (WIDTH),
    .L_ACTIVE(H_ACTIVE),
    .L_FRONT (H_FRONT),
    .L_SYNC  (H_SYNC),
    .L_BACK  (H_BACK)
  ) u_h_axis (
    .i_clk  (aclk),
    .i_rst_n(aresetn),
    .i_tick (w_pix_stb),
    .o_pos  (ord_x),
    .o_state(w_h_state),
    .o_last (w_h_last)
  );

  ibis_vga_axis #(
    .WIDTH   (WIDTH),
    .L_ACTIVE(V_ACTIVE),
    .L_FRONT (V_FRONT),
    .L_SYNC  (V_SYNC),
    .L_BACK  (V_BACK)
  ) u_v_axis (
    .i_clk  (aclk),
    .i_rst_n(aresetn),
    .i_tick (w_pix_stb && w_h_last),
    .o_pos  (ord_y),
    .o_state(w_v_state),
    .o_last (w_v_last)
  );

  // The V segment FSM and the line counter must agree on where the frame ends.
  assert property (@(posedge aclk) disable iff (!aresetn) w_v_last |-> (ord_y == V_LAST));

  assign pix_stb     = w_pix_stb;
  assign hsync       = (w_h_state == SEG_SYNC) ? SYNC_POL : ~SYNC_POL;
  assign vsync       = (w_v_state == SEG_SYNC) ? SYNC_POL : ~SYNC_POL;
  assign active      = (w_h_state == SEG_ACTIVE) && (w_v_state == SEG_ACTIVE);
  assign frame_start = w_pix_stb && (ord_x == '0) && (ord_y == '0);

endmodule

// File: tb/tb_ibis_vga_timing.sv
// Scoreboard bench for ibis_vga_timing on a reduced raster with a divided pixel clock.
module tb_ibis_vga_timing;

  localparam int W   = 8;
  localparam int PD  = 3;
  localparam int HA  = 6;
  localparam int HF  = 2;
  localparam int HS  = 3;
  localparam int HB  = 2;
  localparam int VA  = 3;
  localparam int VF  = 1;
  localparam int VS  = 2;
  localparam int VB  = 2;
  localparam bit POL = 1'b0;
  localparam int HT  = HA + HF + HS + HB;
  localparam int VT  = VA + VF + VS + VB;
  localparam int EW  = 5 + 2 * W;

  // clock / reset
  logic         clk;
  logic         aresetn;
  logic         enable;
  logic         pix_stb;
  logic [W-1:0] ord_x;
  logic [W-1:0] ord_y;
  logic         hsync;
  logic         vsync;
  logic         active;
  logic         frame_start;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ibis_vga_timing #(
    .WIDTH(W), .PIX_DIV(PD),
    .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .SYNC_POL(POL)
  ) dut (
    .aclk(clk), .aresetn(aresetn), .enable(enable),
    .pix_stb(pix_stb), .ord_x(ord_x), .ord_y(ord_y),
    .hsync(hsync), .vsync(vsync), .active(active), .frame_start(frame_start)
  );

  // reference model: pixel phase and raster position as plain integers
  int  m_div;
  int  m_x;
  int  m_y;
  bit  m_valid;
  int  m_fs_cnt;
  int  dut_fs_cnt;
  int  n_tests;
  int  n_fail;
  logic [EW-1:0] exp_q[$];

  initial begin
    m_valid    = 1'b0;
    m_div      = 0;
    m_x        = 0;
    m_y        = 0;
    m_fs_cnt   = 0;
    dut_fs_cnt = 0;
    n_tests    = 0;
    n_fail     = 0;
  end

  // At each negedge: predict this cycle's outputs, then advance to the next cycle.
  always @(negedge clk) begin
    logic e_stb, e_fs, e_hs, e_vs, e_act;
    if (m_valid) begin
      e_stb = enable && (m_div == PD - 1);
      e_fs  = e_stb && (m_x == 0) && (m_y == 0);
      e_hs  = (m_x >= HA + HF && m_x < HA + HF + HS) ? POL : !POL;
      e_vs  = (m_y >= VA + VF && m_y < VA + VF + VS) ? POL : !POL;
      e_act = (m_x < HA) && (m_y < VA);
      exp_q.push_back({e_stb, e_fs, e_hs, e_vs, e_act, W'(m_x), W'(m_y)});
      if (e_fs) m_fs_cnt++;
    end
    if (!aresetn) begin
      m_valid = 1'b1;
      m_div   = 0;
      m_x     = 0;
      m_y     = 0;
    end else if (enable && m_valid) begin
      if (m_div == PD - 1) begin
        m_div = 0;
        if (m_x == HT - 1) begin
          m_x = 0;
          m_y = (m_y == VT - 1) ? 0 : m_y + 1;
        end else begin
          m_x = m_x + 1;
        end
      end else begin
        m_div = m_div + 1;
      end
    end
  end

  // scoreboard monitor
  always @(negedge clk) begin
    logic [EW-1:0] exp_v;
    logic [EW-1:0] got_v;
    #1;
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      got_v = {pix_stb, frame_start, hsync, vsync, active, ord_x, ord_y};
      n_tests++;
      if (got_v !== exp_v) begin
        n_fail++;
        $display("FAIL outputs @%0t: got stb/fs/hs/vs/act=%b x=%0d y=%0d, expected stb/fs/hs/vs/act=%b x=%0d y=%0d",
                 $time, got_v[EW-1 -: 5], got_v[2*W-1 -: W], got_v[W-1:0],
                 exp_v[EW-1 -: 5], exp_v[2*W-1 -: W], exp_v[W-1:0]);
      end
      if (frame_start) dut_fs_cnt++;
    end
  end

  // driver tasks
  task automatic drive(input logic en, input logic rn);
    @(posedge clk);
    #1;
    enable  = en;
    aresetn = rn;
  endtask

  task automatic run(input logic en, input int n);
    for (int i = 0; i < n; i++) drive(en, 1'b1);
  endtask

  task automatic timeout_fail(input string what);
    n_tests++;
    n_fail++;
    $display("FAIL %s: condition not reached within cycle budget", what);
  endtask

  initial begin
    int budget;
    aresetn = 1'b0;
    enable  = 1'b0;
    repeat (3) drive(1'b0, 1'b0);

    // two full frames free-running
    run(1'b1, 2 * HT * VT * PD + 5);

    // freeze mid-line at x=2 for 7 cycles, then resume
    budget = 0;
    while (!(m_x == 2 && m_div == 1) && budget < 200) begin
      drive(1'b1, 1'b1);
      budget++;
    end
    if (budget >= 200) timeout_fail("reach_x2");
    run(1'b0, 7);
    run(1'b1, 20);

    // reset asserted during vertical sync
    budget = 0;
    while (!(m_y == VA + VF && m_x == 4) && budget < 2000) begin
      drive(1'b1, 1'b1);
      budget++;
    end
    if (budget >= 2000) timeout_fail("reach_vsync");
    drive(1'b1, 1'b0);
    run(1'b1, 10);

    // randomized enable gaps with occasional resets
    for (int i = 0; i < 2500; i++) begin
      drive(($urandom_range(0, 3) != 0), ($urandom_range(0, 299) != 0));
    end

    // long enable-high stretch to cover clean frame boundaries again
    run(1'b1, HT * VT * PD + 10);

    @(negedge clk);
    #3;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
    end
    n_tests++;
    if (dut_fs_cnt != m_fs_cnt) begin
      n_fail++;
      $display("FAIL frame_count: got %0d, expected %0d", dut_fs_cnt, m_fs_cnt);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
